// File: rtl/load_store_unit.sv
// Load/store unit between the CPU and a synchronous-read data memory (one-cycle read latency).
// Define LSU_SUBWORD_EN to enable byte/halfword accesses; otherwise only aligned words are legal.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  store,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t                  state_q;
  logic                    store_q;
  logic [1:0]              size_q;
  logic                    sext_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wword_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    done_q;
  logic                    mis_q;
  logic                    we_q;
  logic                    mis_d;

`ifdef LSU_SUBWORD_EN
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] off, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (sz)
      2'b00:   res = sext ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   res = sext ? {{16{h[15]}}, h} : {16'b0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Sub-word stores only: replace the addressed lane(s) of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    if (sz == 2'b00) begin
      mask = 32'h0000_00FF << {off, 3'b000};
      data = {24'b0, wd[7:0]} << {off, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {off[1], 4'b0000};
      data = {16'b0, wd[15:0]} << {off[1], 4'b0000};
    end
    return (old & ~mask) | (data & mask);
  endfunction
`endif

  always_comb begin
    case (size)
`ifdef LSU_SUBWORD_EN
      2'b00:   mis_d = 1'b0;
      2'b01:   mis_d = addr[0];
`endif
      2'b10:   mis_d = |addr[1:0];
      default: mis_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            store_q <= store;
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr[ADDR_WIDTH+1:0];
            wword_q <= wdata;
            if (mis_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else if (store && size == 2'b10) begin
              state_q <= WRITE;
              we_q    <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: state_q <= CAPTURE;
        CAPTURE: begin
`ifdef LSU_SUBWORD_EN
          if (store_q) begin
            wword_q <= store_merge(mem_q, wword_q, size_q, addr_q[1:0]);
            state_q <= WRITE;
            we_q    <= 1'b1;
          end else begin
            rdata_q <= load_extract(mem_q, size_q, addr_q[1:0], sext_q);
            state_q <= DONE;
            done_q  <= 1'b1;
          end
`else
          // Only word loads reach CAPTURE in this build.
          rdata_q <= mem_q;
          state_q <= DONE;
          done_q  <= 1'b1;
`endif
        end
        WRITE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata      = rdata_q;
  assign done       = done_q;
  assign misaligned = mis_q;
  assign busy       = (state_q != IDLE);
  assign mem_addr   = addr_q[ADDR_WIDTH+1:2];
  assign mem_data   = wword_q;
  // Gated with reset so an abandoned store can never reach memory.
  assign mem_we     = we_q & ~reset;

  logic unused_bits;
`ifdef LSU_SUBWORD_EN
  assign unused_bits = ^{addr[31:ADDR_WIDTH+2], store_q};
`else
  assign unused_bits = ^{addr[31:ADDR_WIDTH+2], store_q, size_q, sext_q, addr_q[1:0]};
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural synchronous-read memory.
module tb_load_store_unit;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset, req, store, sign_ext;
  logic [1:0]    size;
  logic [31:0]   addr, wdata, rdata, mem_data, mem_q;
  logic          done, busy, misaligned, mem_we;
  logic [AW-1:0] mem_addr;

  logic          poke_en;
  logic [AW-1:0] poke_a;
  logic [31:0]   poke_d;

  logic [31:0] mem       [0:(1<<AW)-1];
  logic [31:0] model_mem [0:(1<<AW)-1];
  logic [31:0] exp_rdata;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          mis;
    int            lat;
    logic [31:0]   rd;
    logic          we;
    int            we_cyc;
    logic [31:0]   wdat;
    logic [AW-1:0] waddr;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .req(req), .store(store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata), .done(done),
    .busy(busy), .misaligned(misaligned), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (mem_we) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clock); #1;
    poke_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic access(input logic st, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
    exp_t e, g;
    logic [31:0] w, nw;
    logic [AW-1:0] wa;
    logic [1:0] off;
    logic [7:0] b;
    logic [15:0] h;
    bit sub_ok;
    int n, done_n, we_cnt, we_cyc;
    logic [31:0] we_dat, obs_rd;
    logic [AW-1:0] we_adr;
    logic obs_mis;
`ifdef LSU_SUBWORD_EN
    sub_ok = 1'b1;
`else
    sub_ok = 1'b0;
`endif
    wa  = a[AW+1:2];
    off = a[1:0];
    e.mis = (sz == 2'b11) || (sz == 2'b10 && off != 2'b00) ||
            (sz == 2'b01 && (!sub_ok || off[0])) || (sz == 2'b00 && !sub_ok);
    e.waddr = wa; e.we = 1'b0; e.we_cyc = 0; e.wdat = '0;
    w = model_mem[wa];
    if (e.mis) begin
      e.lat = 1;
    end else if (st) begin
      nw = w;
      case (sz)
        2'b00:   nw[int'(off)*8 +: 8] = wd[7:0];
        2'b01:   nw[int'(off[1])*16 +: 16] = wd[15:0];
        default: nw = wd;
      endcase
      e.we = 1'b1; e.wdat = nw;
      e.we_cyc = (sz == 2'b10) ? 1 : 3;
      e.lat = e.we_cyc + 1;
      model_mem[wa] = nw;
    end else begin
      b = w[int'(off)*8 +: 8];
      h = w[int'(off[1])*16 +: 16];
      case (sz)
        2'b00:   exp_rdata = {(sx && b[7]) ? 24'hFFFFFF : 24'h0, b};
        2'b01:   exp_rdata = {(sx && h[15]) ? 16'hFFFF : 16'h0, h};
        default: exp_rdata = w;
      endcase
      e.lat = 3;
    end
    e.rd = exp_rdata;
    sb.push_back(e);

    @(posedge clock); #1;
    req = 1'b1; store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
    @(posedge clock); #1;
    // Garbage request while busy must be ignored and must not disturb latched fields.
    req = 1'b1; store = ~st; size = ~sz; sign_ext = ~sx; addr = $urandom; wdata = $urandom;
    n = 1; done_n = 0; we_cnt = 0; we_cyc = 0; we_dat = '0; we_adr = '0;
    obs_mis = 1'b0; obs_rd = '0;
    while (n <= 8 && done_n == 0) begin
      if (n == 1) begin
        check_eq("busy_t1", 32'(busy), 32'd1);
        if (!e.mis) check_eq("mem_addr_t1", 32'(mem_addr), 32'(wa));
      end
      if (mem_we) begin
        we_cnt++; we_cyc = n; we_dat = mem_data; we_adr = mem_addr;
      end
      if (done) begin
        done_n = n; obs_mis = misaligned; obs_rd = rdata;
        req = 1'b0;
      end else begin
        @(posedge clock); #1;
        n++;
      end
    end
    req = 1'b0;
    if (done_n == 0) check_eq("done_timeout", 32'd0, 32'd1);
    g = sb.pop_front();
    check_eq("latency", 32'(done_n), 32'(g.lat));
    check_eq("misaligned", 32'(obs_mis), 32'(g.mis));
    check_eq("rdata", obs_rd, g.rd);
    check_eq("we_count", 32'(we_cnt), 32'(g.we));
    if (g.we) begin
      check_eq("we_cycle", 32'(we_cyc), 32'(g.we_cyc));
      check_eq("we_data", we_dat, g.wdat);
      check_eq("we_addr", 32'(we_adr), 32'(g.waddr));
    end
    @(posedge clock); #1;
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic reset_in_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [AW-1:0] wa;
    int n;
    wa = a[AW+1:2];
    @(posedge clock); #1;
    req = 1'b1; store = 1'b1; size = sz; sign_ext = 1'b0; addr = a; wdata = wd;
    @(posedge clock); #1;
    req = 1'b0;
    n = 1;
    while (!mem_we && n < 8) begin
      @(posedge clock); #1;
      n++;
    end
    check_eq("rst_we_seen", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_we_gated", 32'(mem_we), 32'd0);
    @(posedge clock); #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    exp_rdata = '0;
    @(posedge clock); #1;
    check_eq("rst_busy_after", 32'(busy), 32'd0);
    check_eq("rst_mem_kept", mem[wa], model_mem[wa]);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; store = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    exp_rdata = '0;
    for (int i = 0; i < 64; i++) poke(AW'(i), $urandom);

    check_eq("reset_rdata", rdata, 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_mis", 32'(misaligned), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_we", 32'(mem_we), 32'd0);
    reset = 1'b0;

    poke(AW'(4), 32'hDEADBEEF);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    poke(AW'(4), 32'h80FF1234);
    access(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    poke(AW'(8), 32'h11223344);
    access(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
    access(1'b1, 2'b00, 1'b0, 32'h04, 32'h0000005A);
    access(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    access(1'b0, 2'b01, 1'b1, 32'h21, 32'h0);
    access(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678);
    access(1'b0, 2'b10, 1'b0, 32'hFFFF_C030, 32'h0);
    access(1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    access(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);
    for (int k = 0; k < 4; k++) access(1'b1, 2'b00, 1'b0, 32'h40 + k, 32'hC0 + k);
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);

    for (int r = 0; r < 40; r++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ($urandom & 32'hFFFF_C0FF), $urandom);
    end

`ifdef LSU_SUBWORD_EN
    reset_in_write(2'b01, 32'h22, 32'h00005555);
`else
    reset_in_write(2'b10, 32'h24, 32'h55555555);
`endif
    access(1'b0, 2'b10, 1'b0, 32'h24, 32'h0);

    for (int i = 0; i < 64; i++) check_eq("mem_final", mem[i], model_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
